if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage.sv | 123 ++++++++++++
 tb/tb_if_id_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register for a synchronous-read instruction memory with a one-entry stall skid
//
// Purpose:
//   Pairs each word coming back from the synchronous instruction memory with
//   the PC that addressed it one cycle earlier (the fetch tag). The pair is
//   presented to decode. While decode is stalled, the word already in flight
//   is parked in a one-entry skid buffer so it is neither lost nor duplicated.
//   A flush discards everything in flight and inserts NOP bubbles.
//
// Parameters:
//   REG_DATA_WIDTH   width of the PC and instruction fields
//   IMEM_ADDR_WIDTH  instruction memory word-address width
//
// Ports:
//   Clk             system clock, rising edge
//   Reset_n         synchronous active-low reset
//   PC_In           current fetch PC (word index)
//   IMEM_Addr       instruction memory read address (low bits of PC_In)
//   IMEM_Data       memory read data, valid one cycle after its address
//   IFID_Stall      hold the decode outputs (upstream PC holds as well)
//   IFID_Flush      discard wrong-path fetches; wins over IFID_Stall
//   ID_PC           PC of the instruction presented to decode
//   ID_Instr        instruction presented to decode (NOP when not valid)
//   ID_Valid        ID_Instr is a real instruction
//   IF_Fetch_Count  number of valid instructions delivered to decode
//
// Optional feature:
//   IF_PERF_CNT_EN  when defined, IF_Fetch_Count is a wrapping delivery counter;
//                   otherwise it is tied to zero and no counter is built.

module if_id_stage #(
    parameter int REG_DATA_WIDTH  = 32,
    parameter int IMEM_ADDR_WIDTH = 10
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [REG_DATA_WIDTH-1:0]  PC_In,
    output logic [IMEM_ADDR_WIDTH-1:0] IMEM_Addr,
    input  logic [REG_DATA_WIDTH-1:0]  IMEM_Data,
    input  logic                       IFID_Stall,
    input  logic                       IFID_Flush,
    output logic [REG_DATA_WIDTH-1:0]  ID_PC,
    output logic [REG_DATA_WIDTH-1:0]  ID_Instr,
    output logic                       ID_Valid,
    output logic [31:0]                IF_Fetch_Count
);

    localparam logic [REG_DATA_WIDTH-1:0] NOP_INSTR = REG_DATA_WIDTH'(32'h0000_0013);

    // Fetch tag: names the PC whose data is currently on IMEM_Data.
    logic [REG_DATA_WIDTH-1:0] f_pc;
    logic                      f_valid;

    // Skid entry: holds the word that arrived while decode was stalled.
    logic [REG_DATA_WIDTH-1:0] s_pc;
    logic [REG_DATA_WIDTH-1:0] s_instr;
    logic                      s_valid;

    assign IMEM_Addr = PC_In[IMEM_ADDR_WIDTH-1:0];

    // The memory is re-read every cycle, so the tag simply follows PC_In.
    // A flush kills the word that the current (wrong-path) PC will return.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            f_pc    <= '0;
            f_valid <= 1'b0;
        end else begin
            f_pc    <= PC_In;
            f_valid <= !IFID_Flush;
        end
    end

    // Skid entry and decode-facing register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s_valid  <= 1'b0;
            ID_PC    <= '0;
            ID_Instr <= NOP_INSTR;
            ID_Valid <= 1'b0;
        end else if (IFID_Flush) begin
            // ID_PC deliberately held: only the valid bit and payload are killed.
            s_valid  <= 1'b0;
            ID_Instr <= NOP_INSTR;
            ID_Valid <= 1'b0;
        end else if (IFID_Stall) begin
            // Only the first in-flight word of a stall needs parking: the
            // upstream PC is frozen, so later cycles re-read the next PC,
            // which is fetched again after release.
            if (f_valid && !s_valid) begin
                s_pc    <= f_pc;
                s_instr <= IMEM_Data;
                s_valid <= 1'b1;
            end
        end else if (s_valid) begin
            ID_PC    <= s_pc;
            ID_Instr <= s_instr;
            ID_Valid <= 1'b1;
            s_valid  <= 1'b0;
        end else begin
            ID_PC    <= f_pc;
            ID_Instr <= f_valid ? IMEM_Data : NOP_INSTR;
            ID_Valid <= f_valid;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;

    // Counts exactly the edges on which decode is loaded with a valid word.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            fetch_cnt_q <= '0;
        end else if (!IFID_Flush && !IFID_Stall && (s_valid || f_valid)) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign IF_Fetch_Count = fetch_cnt_q;
`else
    assign IF_Fetch_Count = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - self-checking bench for if_id_stage with an in-order delivery scoreboard

module tb_if_id_stage;

    logic        Clk;
    logic        Reset_n;
    logic [31:0] PC_In;
    logic [9:0]  IMEM_Addr;
    logic [31:0] IMEM_Data;
    logic        IFID_Stall;
    logic        IFID_Flush;
    logic [31:0] ID_PC;
    logic [31:0] ID_Instr;
    logic        ID_Valid;
    logic [31:0] IF_Fetch_Count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] pc;
    logic [31:0] exp_cnt;
    logic [63:0] exp_q[$];

    if_id_stage #(
        .REG_DATA_WIDTH (32),
        .IMEM_ADDR_WIDTH(10)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .PC_In         (PC_In),
        .IMEM_Addr     (IMEM_Addr),
        .IMEM_Data     (IMEM_Data),
        .IFID_Stall    (IFID_Stall),
        .IFID_Flush    (IFID_Flush),
        .ID_PC         (ID_PC),
        .ID_Instr      (ID_Instr),
        .ID_Valid      (ID_Valid),
        .IF_Fetch_Count(IF_Fetch_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] instr_of(input logic [31:0] p);
        return {22'd0, p[9:0]} + 32'h100;
    endfunction

    // Synchronous instruction memory: IMEM[n] = n + 0x100.
    always @(posedge Clk) IMEM_Data <= instr_of({22'd0, IMEM_Addr});

    // One clock of stimulus plus the upstream PC model and the scoreboard.
    // A PC is consumed (and expected at decode) on edges with no stall, flush or reset.
    task automatic cycle(input logic stall, input logic flush, input logic rstn,
                         input logic [31:0] next_pc);
        logic [63:0] e;
        Reset_n    = rstn;
        IFID_Stall = stall;
        IFID_Flush = flush;
        PC_In      = pc;
        @(posedge Clk);
        #1;
        if (!rstn) begin
            exp_q.delete();
            exp_cnt = 32'd0;
            pc      = next_pc;
        end else if (flush) begin
            exp_q.delete();
            pc = next_pc;
        end else if (!stall) begin
            exp_q.push_back({pc, instr_of(pc)});
            pc = pc + 32'd1;
            if (ID_Valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_extra: got pc=%h instr=%h required no delivery", ID_PC, ID_Instr);
                end else begin
                    e = exp_q.pop_front();
                    if ({ID_PC, ID_Instr} !== e)
                        $display("FAIL sb_order: got pc=%h instr=%h required pc=%h instr=%h",
                                 ID_PC, ID_Instr, e[63:32], e[31:0]);
                    else
                        n_pass++;
                end
`ifdef IF_PERF_CNT_EN
                exp_cnt = exp_cnt + 32'd1;
`endif
            end
        end
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0);
        n_checks++; if (ID_PC !== 32'd0) $display("FAIL rst_pc: got %h required 0", ID_PC); else n_pass++;
        n_checks++; if (ID_Instr !== 32'h13) $display("FAIL rst_instr: got %h required 13", ID_Instr); else n_pass++;
        n_checks++; if (ID_Valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", ID_Valid); else n_pass++;
        n_checks++; if (IF_Fetch_Count !== 32'd0) $display("FAIL rst_cnt: got %h required 0", IF_Fetch_Count); else n_pass++;
    endtask

    task automatic test_straight();
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
        n_checks++; if (ID_Valid !== 1'b0) $display("FAIL first_bubble: got %b required 0", ID_Valid); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'd0);
            n_checks++;
            if ({ID_PC, ID_Instr, ID_Valid} !== {32'(k), 32'h100 + 32'(k), 1'b1})
                $display("FAIL straight_e%0d: got %h/%h/%b required %h/%h/1",
                         k + 2, ID_PC, ID_Instr, ID_Valid, k, 32'h100 + 32'(k));
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
        n_checks++; if (ID_PC !== 32'd4) $display("FAIL stall_pre: got %h required 4", ID_PC); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 32'd0);
            n_checks++;
            if ({ID_PC, ID_Instr, ID_Valid} !== {32'd4, 32'h104, 1'b1})
                $display("FAIL stall_hold%0d: got %h/%h/%b required 4/104/1", k, ID_PC, ID_Instr, ID_Valid);
            else n_pass++;
        end
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
        n_checks++;
        if ({ID_PC, ID_Instr, ID_Valid} !== {32'd5, 32'h105, 1'b1})
            $display("FAIL stall_rel5: got %h/%h/%b required 5/105/1", ID_PC, ID_Instr, ID_Valid);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
        n_checks++;
        if ({ID_PC, ID_Instr, ID_Valid} !== {32'd6, 32'h106, 1'b1})
            $display("FAIL stall_rel6: got %h/%h/%b required 6/106/1", ID_PC, ID_Instr, ID_Valid);
        else n_pass++;
        n_checks++; if (IF_Fetch_Count !== exp_cnt) $display("FAIL stall_cnt: got %h required %h", IF_Fetch_Count, exp_cnt); else n_pass++;
    endtask

    task automatic test_flush();
        cycle(1'b0, 1'b1, 1'b1, 32'h40);
        n_checks++;
        if ({ID_PC, ID_Instr, ID_Valid} !== {32'd6, 32'h13, 1'b0})
            $display("FAIL flush_e1: got %h/%h/%b required 6/13/0", ID_PC, ID_Instr, ID_Valid);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
        n_checks++;
        if ({ID_Instr, ID_Valid} !== {32'h13, 1'b0})
            $display("FAIL flush_e2: got %h/%b required 13/0", ID_Instr, ID_Valid);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
        n_checks++;
        if ({ID_PC, ID_Instr, ID_Valid} !== {32'h40, 32'h140, 1'b1})
            $display("FAIL flush_target: got %h/%h/%b required 40/140/1", ID_PC, ID_Instr, ID_Valid);
        else n_pass++;
    endtask

    task automatic test_stall_flush();
        cycle(1'b1, 1'b0, 1'b1, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 32'h80);
        n_checks++;
        if ({ID_Instr, ID_Valid} !== {32'h13, 1'b0})
            $display("FAIL sf_kill: got %h/%b required 13/0", ID_Instr, ID_Valid);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
        n_checks++;
        if (ID_Valid !== 1'b0) $display("FAIL sf_no_skid: got valid=%b pc=%h required 0", ID_Valid, ID_PC); else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
        n_checks++;
        if ({ID_PC, ID_Valid} !== {32'h80, 1'b1})
            $display("FAIL sf_target: got %h/%b required 80/1", ID_PC, ID_Valid);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
    endtask

    task automatic test_reset_mid_stall();
        cycle(1'b1, 1'b0, 1'b1, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'h30);
        n_checks++;
        if ({ID_PC, ID_Instr, ID_Valid} !== {32'd0, 32'h13, 1'b0})
            $display("FAIL rms_state: got %h/%h/%b required 0/13/0", ID_PC, ID_Instr, ID_Valid);
        else n_pass++;
        n_checks++; if (IF_Fetch_Count !== 32'd0) $display("FAIL rms_cnt: got %h required 0", IF_Fetch_Count); else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
        n_checks++; if (ID_Valid !== 1'b0) $display("FAIL rms_bubble: got %b required 0", ID_Valid); else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
        n_checks++;
        if ({ID_PC, ID_Valid} !== {32'h30, 1'b1})
            $display("FAIL rms_first: got %h/%b required 30/1", ID_PC, ID_Valid);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b1, 32'd0);
    endtask

    task automatic test_counter();
`ifdef IF_PERF_CNT_EN
        force dut.fetch_cnt_q = 32'hFFFF_FFFE;
        cycle(1'b1, 1'b0, 1'b1, 32'd0);
        release dut.fetch_cnt_q;
        exp_cnt = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 32'd0);
        n_checks++; if (IF_Fetch_Count !== 32'd1) $display("FAIL cnt_wrap: got %h required 1", IF_Fetch_Count); else n_pass++;
`else
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 32'd0);
        n_checks++; if (IF_Fetch_Count !== 32'd0) $display("FAIL cnt_off: got %h required 0", IF_Fetch_Count); else n_pass++;
`endif
        n_checks++; if (IF_Fetch_Count !== exp_cnt) $display("FAIL cnt_model: got %h required %h", IF_Fetch_Count, exp_cnt); else n_pass++;
    endtask

    initial begin
        pc         = 32'd0;
        exp_cnt    = 32'd0;
        Reset_n    = 1'b0;
        IFID_Stall = 1'b0;
        IFID_Flush = 1'b0;
        PC_In      = 32'd0;
        test_reset();
        test_straight();
        test_stall();
        test_flush();
        test_stall_flush();
        test_reset_mid_stall();
        test_counter();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
